// File: rtl/dma32_mem_responder_if.sv
// Bundles the 32-bit accelerator DMA handshake signals: read/write control requests and data channels.
// Latency: none, wires only.
// Backpressure: every control request and data channel is a valid/ready pair.
// Ports (master = accelerator side, slave = memory responder side):
//   dma_{read,write}_ctrl_{valid,ready,data_index,data_length,data_size}
//   dma_read_chnl_{valid,ready,data}, dma_write_chnl_{valid,ready,data}
interface dma32_mem_responder_if;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [31:0] dma_read_chnl_data;

  logic        dma_write_ctrl_valid;
  logic        dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index;
  logic [31:0] dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic        dma_write_chnl_valid;
  logic        dma_write_chnl_ready;
  logic [31:0] dma_write_chnl_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );
endinterface

// File: rtl/dma32_mem_responder.sv
// Memory-side responder for dma32 accelerators: serves read/write bursts from an internal word memory.
// Latency: first read beat / write ready one cycle after the ctrl handshake, then 1 word/cycle.
// Backpressure: read data held stable while not accepted; write channel stalls on !valid.
// Ports: clk, rst (sync, active-high); dma (slave modport of the DMA interface);
//   bd_we/bd_addr/bd_wdata/bd_rdata backdoor memory access (bd_rdata registered);
//   rd_done/wr_done one-cycle burst-complete pulses; err_size/err_oob sticky error flags.
module dma32_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  dma32_mem_responder_if.slave   dma,
  input  logic                   bd_we,
  input  logic [AW-1:0]          bd_addr,
  input  logic [31:0]            bd_wdata,
  output logic [31:0]            bd_rdata,
  output logic                   rd_done,
  output logic                   wr_done,
  output logic                   err_size,
  output logic                   err_oob
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_WORDS);

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [31:0]   remaining;
  // Unwrapped index of the current beat; one extra bit so index+beat never overflows.
  logic [32:0]   uidx;
  logic [31:0]   mem [MEM_WORDS];

  logic        rd_hs, wr_hs, hs, rd_beat, wr_beat, last_beat;
  logic [31:0] req_index, req_length;
  logic [2:0]  req_size;

  always_comb begin
    state_nxt                = state;
    dma.dma_read_ctrl_ready  = 1'b0;
    dma.dma_write_ctrl_ready = 1'b0;
    dma.dma_read_chnl_valid  = 1'b0;
    dma.dma_write_chnl_ready = 1'b0;

    // Channel outputs are also gated by rst so a burst cut by reset moves no data.
    if (!rst) begin
      case (state)
        IDLE: begin
          dma.dma_read_ctrl_ready  = 1'b1;
          // Read wins a simultaneous request; the write waits for the next IDLE cycle.
          dma.dma_write_ctrl_ready = !dma.dma_read_ctrl_valid;
        end
        RD:      dma.dma_read_chnl_valid  = 1'b1;
        WR:      dma.dma_write_chnl_ready = 1'b1;
        default: ;
      endcase
    end

    rd_hs     = dma.dma_read_ctrl_valid  && dma.dma_read_ctrl_ready;
    wr_hs     = dma.dma_write_ctrl_valid && dma.dma_write_ctrl_ready;
    hs        = rd_hs || wr_hs;
    rd_beat   = dma.dma_read_chnl_valid  && dma.dma_read_chnl_ready;
    wr_beat   = dma.dma_write_chnl_valid && dma.dma_write_chnl_ready;
    last_beat = (rd_beat || wr_beat) && (remaining == 32'd1);

    req_index  = rd_hs ? dma.dma_read_ctrl_data_index  : dma.dma_write_ctrl_data_index;
    req_length = rd_hs ? dma.dma_read_ctrl_data_length : dma.dma_write_ctrl_data_length;
    req_size   = rd_hs ? dma.dma_read_ctrl_data_size   : dma.dma_write_ctrl_data_size;

    case (state)
      IDLE: begin
        if (rd_hs && req_length != 32'd0)      state_nxt = RD;
        else if (wr_hs && req_length != 32'd0) state_nxt = WR;
      end
      RD:      if (rd_beat && last_beat) state_nxt = IDLE;
      WR:      if (wr_beat && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dma.dma_read_chnl_data = mem[addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      uidx      <= '0;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
      err_size  <= 1'b0;
      err_oob   <= 1'b0;
      bd_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      bd_rdata <= mem[bd_addr];

      if (hs) begin
        addr      <= req_index[AW-1:0];
        remaining <= req_length;
        uidx      <= {1'b0, req_index};
        if (req_size != 3'b010) err_size <= 1'b1;
        // Zero-length burst: nothing to move, complete immediately.
        if (req_length == 32'd0) begin
          rd_done <= rd_hs;
          wr_done <= wr_hs;
        end
      end

      if (rd_beat || wr_beat) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 32'd1;
        uidx      <= uidx + 33'd1;
        if (uidx >= MEM_LIMIT) err_oob <= 1'b1;
        if (last_beat) begin
          rd_done <= rd_beat;
          wr_done <= wr_beat;
        end
      end
    end
  end

  // Memory is never reset. A channel write takes priority over a backdoor write.
  always_ff @(posedge clk) begin
    if (wr_beat) mem[addr] <= dma.dma_write_chnl_data;
    else if (bd_we) mem[bd_addr] <= bd_wdata;
  end

endmodule

// File: tb/tb_dma32_mem_responder.sv
module tb_dma32_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_wdata;
  logic [31:0] bd_rdata;
  logic        rd_done, wr_done, err_size, err_oob;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] rv;

  dma32_mem_responder_if dma();

  dma32_mem_responder #(.MEM_WORDS(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .dma(dma),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .rd_done(rd_done), .wr_done(wr_done), .err_size(err_size), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int a, input logic [31:0] d);
    bd_addr = 10'(a); bd_wdata = d; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input int a, output logic [31:0] d);
    bd_addr = 10'(a);
    tick();
    d = bd_rdata;
  endtask

  task automatic rd_req(input int idx, input int len, input logic [2:0] size);
    dma.dma_read_ctrl_valid = 1'b1;
    dma.dma_read_ctrl_data_index = 32'(idx);
    dma.dma_read_ctrl_data_length = 32'(len);
    dma.dma_read_ctrl_data_size = size;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++; if (dma.dma_read_ctrl_ready !== 1'b0) begin fails++; $display("FAIL reset_rd_ctrl_ready: got %b want 0", dma.dma_read_ctrl_ready); end
    tests++; if (dma.dma_read_chnl_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", dma.dma_read_chnl_valid); end
    tests++; if (dma.dma_write_chnl_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready: got %b want 0", dma.dma_write_chnl_ready); end
    tests++; if ({rd_done, wr_done, err_size, err_oob} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {rd_done, wr_done, err_size, err_oob}); end
    tests++; if (bd_rdata !== 32'd0) begin fails++; $display("FAIL reset_bd_rdata: got %h want 0", bd_rdata); end
    rst = 1'b0;
    #1;
    tests++; if (dma.dma_read_ctrl_ready !== 1'b1 || dma.dma_write_ctrl_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ctrl_ready: got %b%b want 11", dma.dma_read_ctrl_ready, dma.dma_write_ctrl_ready); end
  endtask

  task automatic test_read_burst();
    for (int i = 0; i < 16; i++) bd_write(i, 32'(i * 3));
    rd_req(4, 4, 3'b010);
    tick();
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++; if (dma.dma_read_chnl_valid !== 1'b1 || dma.dma_read_chnl_data !== 32'(12 + 3 * k)) begin fails++; $display("FAIL read_beat%0d: got v=%b d=%0d want v=1 d=%0d", k, dma.dma_read_chnl_valid, dma.dma_read_chnl_data, 12 + 3 * k); end
      tests++; if (rd_done !== 1'b0) begin fails++; $display("FAIL read_early_done%0d: got %b want 0", k, rd_done); end
      tick();
    end
    tests++; if (rd_done !== 1'b1 || dma.dma_read_chnl_valid !== 1'b0) begin fails++; $display("FAIL read_done: got done=%b v=%b want 1 0", rd_done, dma.dma_read_chnl_valid); end
    tests++; if (dma.dma_read_ctrl_ready !== 1'b1) begin fails++; $display("FAIL read_turnaround_ready: got %b want 1", dma.dma_read_ctrl_ready); end
    tick();
    tests++; if (rd_done !== 1'b0) begin fails++; $display("FAIL read_done_width: got %b want 0", rd_done); end
    dma.dma_read_chnl_ready = 1'b0;
  endtask

  task automatic test_write_burst();
    logic [31:0] wd [3];
    logic        vpat [4];
    int          n;
    wd = '{32'hA5A5_0001, 32'hB6B6_0002, 32'hC7C7_0003};
    vpat = '{1'b1, 1'b0, 1'b1, 1'b1};
    dma.dma_write_ctrl_valid = 1'b1;
    dma.dma_write_ctrl_data_index = 32'd100;
    dma.dma_write_ctrl_data_length = 32'd3;
    dma.dma_write_ctrl_data_size = 3'b010;
    #1;
    tests++; if (dma.dma_write_ctrl_ready !== 1'b1) begin fails++; $display("FAIL write_ctrl_ready: got %b want 1", dma.dma_write_ctrl_ready); end
    tick();
    dma.dma_write_ctrl_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      tests++; if (dma.dma_write_chnl_ready !== 1'b1 || wr_done !== 1'b0) begin fails++; $display("FAIL write_cycle%0d: got rdy=%b done=%b want 1 0", c, dma.dma_write_chnl_ready, wr_done); end
      dma.dma_write_chnl_valid = vpat[c];
      dma.dma_write_chnl_data = vpat[c] ? wd[n] : 32'hFFFF_FFFF;
      if (vpat[c]) n++;
      tick();
    end
    dma.dma_write_chnl_valid = 1'b0;
    tests++; if (wr_done !== 1'b1 || dma.dma_write_chnl_ready !== 1'b0) begin fails++; $display("FAIL write_done: got done=%b rdy=%b want 1 0", wr_done, dma.dma_write_chnl_ready); end
    for (int i = 0; i < 3; i++) begin
      bd_read(100 + i, rv);
      tests++; if (rv !== wd[i]) begin fails++; $display("FAIL write_mem%0d: got %h want %h", 100 + i, rv, wd[i]); end
    end
  endtask

  task automatic test_arbitration();
    rd_req(0, 2, 3'b010);
    dma.dma_write_ctrl_valid = 1'b1;
    dma.dma_write_ctrl_data_index = 32'd200;
    dma.dma_write_ctrl_data_length = 32'd1;
    #1;
    tests++; if (dma.dma_read_ctrl_ready !== 1'b1 || dma.dma_write_ctrl_ready !== 1'b0) begin fails++; $display("FAIL arb_ready: got rd=%b wr=%b want 1 0", dma.dma_read_ctrl_ready, dma.dma_write_ctrl_ready); end
    tick();
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (dma.dma_write_ctrl_ready !== 1'b0 || dma.dma_read_chnl_data !== 32'(3 * k)) begin fails++; $display("FAIL arb_read_beat%0d: got wrdy=%b d=%0d want 0 %0d", k, dma.dma_write_ctrl_ready, dma.dma_read_chnl_data, 3 * k); end
      tick();
    end
    dma.dma_read_chnl_ready = 1'b0;
    #1;
    tests++; if (dma.dma_write_ctrl_ready !== 1'b1 || rd_done !== 1'b1) begin fails++; $display("FAIL arb_write_accept: got wrdy=%b rd_done=%b want 1 1", dma.dma_write_ctrl_ready, rd_done); end
    tick();
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_chnl_valid = 1'b1;
    dma.dma_write_chnl_data = 32'hD00D_0200;
    tick();
    dma.dma_write_chnl_valid = 1'b0;
    tests++; if (wr_done !== 1'b1) begin fails++; $display("FAIL arb_wr_done: got %b want 1", wr_done); end
    bd_read(200, rv);
    tests++; if (rv !== 32'hD00D_0200) begin fails++; $display("FAIL arb_mem200: got %h want d00d0200", rv); end
  endtask

  task automatic test_zero_length();
    rd_req(5, 0, 3'b010);
    tick();
    dma.dma_read_ctrl_valid = 1'b0;
    #1;
    tests++; if (rd_done !== 1'b1 || dma.dma_read_chnl_valid !== 1'b0 || dma.dma_read_ctrl_ready !== 1'b1) begin fails++; $display("FAIL len0: got done=%b v=%b rdy=%b want 1 0 1", rd_done, dma.dma_read_chnl_valid, dma.dma_read_ctrl_ready); end
    tick();
    tests++; if (rd_done !== 1'b0 || dma.dma_read_chnl_valid !== 1'b0) begin fails++; $display("FAIL len0_after: got done=%b v=%b want 0 0", rd_done, dma.dma_read_chnl_valid); end
  endtask

  task automatic test_wrap_and_errors();
    logic [31:0] exp [4];
    bd_write(1022, 32'hDEAD_0FFE);
    bd_write(1023, 32'hDEAD_0FFF);
    exp = '{32'hDEAD_0FFE, 32'hDEAD_0FFF, 32'd0, 32'd3};
    tests++; if (err_oob !== 1'b0 || err_size !== 1'b0) begin fails++; $display("FAIL err_before: got oob=%b size=%b want 0 0", err_oob, err_size); end
    rd_req(1022, 4, 3'b010);
    tick();
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++; if (dma.dma_read_chnl_data !== exp[k]) begin fails++; $display("FAIL wrap_beat%0d: got %h want %h", k, dma.dma_read_chnl_data, exp[k]); end
      tests++; if (err_oob !== (k >= 3)) begin fails++; $display("FAIL oob_timing%0d: got %b want %b", k, err_oob, k >= 3); end
      tick();
    end
    dma.dma_read_chnl_ready = 1'b0;
    tests++; if (err_oob !== 1'b1 || rd_done !== 1'b1 || err_size !== 1'b0) begin fails++; $display("FAIL wrap_end: got oob=%b done=%b size=%b want 1 1 0", err_oob, rd_done, err_size); end
    rd_req(8, 1, 3'b011);
    tick();
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    #1;
    tests++; if (err_size !== 1'b1 || dma.dma_read_chnl_data !== 32'd24) begin fails++; $display("FAIL size_err: got size=%b d=%0d want 1 24", err_size, dma.dma_read_chnl_data); end
    tick();
    dma.dma_read_chnl_ready = 1'b0;
    tests++; if (rd_done !== 1'b1 || err_size !== 1'b1) begin fails++; $display("FAIL size_done: got done=%b size=%b want 1 1", rd_done, err_size); end
  endtask

  task automatic test_reset_mid_burst();
    rd_req(0, 8, 3'b010);
    tick();
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_chnl_ready = 1'b1;
    tick(); tick();
    tests++; if (dma.dma_read_chnl_valid !== 1'b1 || dma.dma_read_chnl_data !== 32'd6) begin fails++; $display("FAIL mid_third_beat: got v=%b d=%0d want 1 6", dma.dma_read_chnl_valid, dma.dma_read_chnl_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dma.dma_read_chnl_ready = 1'b0;
    #1;
    tests++; if (dma.dma_read_chnl_valid !== 1'b0 || rd_done !== 1'b0) begin fails++; $display("FAIL mid_reset_out: got v=%b done=%b want 0 0", dma.dma_read_chnl_valid, rd_done); end
    tests++; if (err_oob !== 1'b0 || err_size !== 1'b0) begin fails++; $display("FAIL mid_reset_err: got oob=%b size=%b want 0 0", err_oob, err_size); end
    tests++; if (dma.dma_read_ctrl_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b want 1", dma.dma_read_ctrl_ready); end
    tick();
    tests++; if (rd_done !== 1'b0) begin fails++; $display("FAIL mid_reset_no_done: got %b want 0", rd_done); end
    bd_read(2, rv);
    tests++; if (rv !== 32'd6) begin fails++; $display("FAIL mid_reset_mem2: got %h want 6", rv); end
    bd_read(1023, rv);
    tests++; if (rv !== 32'hDEAD_0FFF) begin fails++; $display("FAIL mid_reset_mem1023: got %h want dead0fff", rv); end
  endtask

  initial begin
    rst = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_ctrl_data_index = '0;
    dma.dma_read_ctrl_data_length = '0;
    dma.dma_read_ctrl_data_size = 3'b010;
    dma.dma_read_chnl_ready = 1'b0;
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_ctrl_data_index = '0;
    dma.dma_write_ctrl_data_length = '0;
    dma.dma_write_ctrl_data_size = 3'b010;
    dma.dma_write_chnl_valid = 1'b0;
    dma.dma_write_chnl_data = '0;

    test_reset();
    test_read_burst();
    test_write_burst();
    test_arbitration();
    test_zero_length();
    test_wrap_and_errors();
    test_reset_mid_burst();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dma32_mem_responder.md
# dma32_mem_responder

- Memory-side responder for the 32-bit ESP accelerator DMA interface: accepts read and write control requests from an accelerator and serves them from an internal word-addressed memory.
- On reads it streams words out on the read channel; on writes it sinks words from the write channel into memory.
- Used as the bench/emulation counterpart of every dma32 accelerator. It also exposes a backdoor port so the bench can preload memory and check results.

## Interface
Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; power of two.
- AW, log2(MEM_WORDS), word-address width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- dma_read_ctrl_valid  input  1  read request valid.
- dma_read_ctrl_ready  output  1  read request accepted.
- dma_read_ctrl_data_index  input  32  first word index.
- dma_read_ctrl_data_length  input  32  number of words.
- dma_read_ctrl_data_size  input  3  beat size; only 3'b010 (32-bit) is legal.
- dma_read_chnl_valid  output  1  read data valid.
- dma_read_chnl_ready  input  1  accelerator accepts read data.
- dma_read_chnl_data  output  32  read data.
- dma_write_ctrl_valid / _ready / _data_index / _data_length / _data_size: same widths and meaning as the read control port, for writes.
- dma_write_chnl_valid  input  1  write data valid.
- dma_write_chnl_ready  output  1  responder accepts write data.
- dma_write_chnl_data  input  32  write data.
- bd_we  input  1  backdoor write enable.
- bd_addr  input  AW  backdoor address.
- bd_wdata  input  32  backdoor write data.
- bd_rdata  output  32  backdoor read data, registered.
- rd_done  output  1  one-cycle pulse when a read burst completes.
- wr_done  output  1  one-cycle pulse when a write burst completes.
- err_size  output  1  sticky: a request had size != 3'b010.
- err_oob  output  1  sticky: a burst touched an index >= MEM_WORDS.

## Operation
- FSM states: IDLE, RD, WR.
- Both ctrl ready outputs are asserted only in IDLE. When both ctrl valids are high in the same cycle, read wins: only dma_read_ctrl_ready is asserted, and the write request waits.
- On a ctrl handshake, the responder captures the index into addr (AW bits, taken modulo MEM_WORDS) and the length into remaining (32 bits).
  - If length==0, the FSM stays in IDLE and pulses the matching done signal in the next cycle.
  - Otherwise the FSM goes to RD or WR.
- A handshake with size != 3'b010 sets err_size; the transfer still proceeds as 32-bit words.
- RD state:
  - dma_read_chnl_valid=1 and dma_read_chnl_data=mem[addr].
  - On valid&&ready: addr+1 (wraps at MEM_WORDS), remaining-1.
  - On the last beat: rd_done pulse next cycle, FSM returns to IDLE.
- WR state:
  - dma_write_chnl_ready=1.
  - On valid&&ready: mem[addr] is written with the data, addr+1 (wraps), remaining-1.
  - On the last beat: ready drops next cycle, wr_done pulse, FSM returns to IDLE.
- Any beat whose unwrapped index (captured index + beat number) is >= MEM_WORDS sets err_oob.
- Backdoor:
  - bd_we writes mem[bd_addr] at the clock edge.
  - bd_rdata = mem[bd_addr] one cycle later.
  - If a channel write and a backdoor write hit the same address in the same cycle, the channel write wins.
- Reset:
  - FSM returns to IDLE; all valid/ready/done/err outputs go to 0; bd_rdata goes to 0.
  - Memory contents are preserved.
  - Reset in the middle of a burst abandons the burst; no done pulse is generated.

## Timing
- Ctrl ready is combinational: state==IDLE and not in reset.
- Read latency: first dma_read_chnl_valid appears in the cycle after the ctrl handshake.
- While valid && !ready, data is held stable.
- Back-to-back read beats run at 1 word/cycle when ready is held high.
- Write: dma_write_chnl_ready rises in the cycle after the ctrl handshake and sustains 1 word/cycle.
- A new ctrl ready is asserted in the cycle after the last beat's handshake.
  - Minimum burst turnaround: last beat (cycle N), IDLE with ready=1 (N+1), next handshake possible in N+1.
- done pulses are high in cycle N+1, exactly one cycle.
- err flags assert in the cycle after the offending handshake or beat, and clear only on rst.

## Test plan
- Preload words 0..15 with value i*3 via the backdoor. Read request index=4, length=4, ready held high -> data 12,15,18,21 on four consecutive cycles; rd_done pulses once.
- Write request index=100, length=3, data A,B,C, accelerator valid toggling 1,0,1,1 -> memory[100..102]=A,B,C; wr_done fires after the third accepted beat; a backdoor read confirms the values.
- Read and write ctrl valid in the same cycle -> read accepted first; the write is accepted in the cycle after the read's last beat.
- length=0 read -> no chnl_valid; rd_done pulses the cycle after the handshake.
- Read with MEM_WORDS=1024, index=1022, length=4 -> data mem[1022], mem[1023], mem[0], mem[1]; err_oob=1. A separate request with size=3'b011 -> err_size=1, transfer still completes.
- Assert rst during the third beat of an 8-beat read -> valid=0 the cycle after rst, no rd_done, ctrl ready=1 once rst drops. Memory is unchanged, as checked by the backdoor.
